trigger_capture: RTL and testbench

Receive-side counterpart of the per-channel trigger generator: measures each incoming trigger pulse against the BSYNC reference. For every pulse it reports phase (cycles from latest reference rising edge to trigger rising edge) and width (cycles high), plus error flags, over a valid/ready interface. Sits in axi_adf4030 loopback/monitor paths, one instance per monitored channel, same clock as the trigger channels.

---
 rtl/trigger_pkg.sv | 28 ++
 rtl/trigger_edge_detect.sv | 28 ++
 rtl/trigger_capture.sv | 145 ++++++++++++++
 tb/tb_trigger_capture.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Shared types and constants for the trigger capture block.
package trigger_pkg;

  localparam int CNT_WIDTH_DEF  = 16;
  localparam int DROP_WIDTH_DEF = 8;

  localparam int ERR_MISMATCH = 0;
  localparam int ERR_TIMEOUT  = 1;
  localparam int ERR_WSAT     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PHASE_COUNT,
    ST_WIDTH_COUNT,
    ST_REPORT
  } cap_state_t;

  function automatic logic [2:0] err_pack(input logic wsat, input logic tmo, input logic mis);
    logic [2:0] e;
    e               = '0;
    e[ERR_WSAT]     = wsat;
    e[ERR_TIMEOUT]  = tmo;
    e[ERR_MISMATCH] = mis;
    return e;
  endfunction

endpackage

// File: rtl/trigger_edge_detect.sv
// Two-flop sampler producing the sampled level plus single-cycle rise/fall strobes.
module trigger_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;
  logic r_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
      r_d <= 1'b0;
    end else begin
      r_q <= i_in;
      r_d <= r_q;
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_q & ~r_d;
  assign o_fall = ~r_q & r_d;

endmodule

// File: rtl/trigger_capture.sv
// Measures phase of each trigger pulse against the latest BSYNC rising edge, plus its
// high width, and hands the result out over a valid/ready interface.
module trigger_capture
  import trigger_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int DROP_WIDTH = DROP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ch_en,
  input  logic                  bsync_ref,
  input  logic                  trig_in,
  input  logic [CNT_WIDTH-1:0]  bsync_ratio,
  input  logic [CNT_WIDTH-1:0]  timeout_limit,
  output logic                  meas_valid,
  input  logic                  meas_ready,
  output logic [CNT_WIDTH-1:0]  meas_phase,
  output logic [CNT_WIDTH-1:0]  meas_width,
  output logic [2:0]            meas_err,
  output logic [DROP_WIDTH-1:0] drop_cnt
);

  logic w_ref_rise, w_ref_q_unused, w_ref_fall_unused;
  logic w_trig_rise, w_trig_q, w_trig_fall;

  trigger_edge_detect u_ref_edge (
    .clk    (clk),
    .rst    (rst),
    .i_in   (bsync_ref),
    .o_q    (w_ref_q_unused),
    .o_rise (w_ref_rise),
    .o_fall (w_ref_fall_unused)
  );

  trigger_edge_detect u_trig_edge (
    .clk    (clk),
    .rst    (rst),
    .i_in   (trig_in),
    .o_q    (w_trig_q),
    .o_rise (w_trig_rise),
    .o_fall (w_trig_fall)
  );

  cap_state_t            r_state;
  logic [CNT_WIDTH-1:0]  r_phase_cnt;
  logic [CNT_WIDTH-1:0]  r_phase_cap;
  logic [CNT_WIDTH-1:0]  r_width_cnt;
  logic                  r_wsat;
  logic                  r_valid;
  logic [CNT_WIDTH-1:0]  r_phase;
  logic [CNT_WIDTH-1:0]  r_width;
  logic [2:0]            r_err;
  logic [DROP_WIDTH-1:0] r_drop;
  logic                  w_drop_evt;

  // Edges that arrive while a result is pending, or with no reference yet, are lost.
  assign w_drop_evt = w_trig_rise &&
                      ((r_state == ST_REPORT) ||
                       (r_state == ST_ARMED && ch_en && !w_ref_rise));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phase_cnt <= '0;
      r_phase_cap <= '0;
      r_width_cnt <= '0;
      r_wsat      <= 1'b0;
      r_valid     <= 1'b0;
      r_phase     <= '0;
      r_width     <= '0;
      r_err       <= '0;
      r_drop      <= '0;
    end else begin
      if (w_drop_evt && r_drop != '1) r_drop <= r_drop + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (ch_en) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (!ch_en) begin
            r_state <= ST_IDLE;
          end else if (w_ref_rise && w_trig_rise) begin
            r_phase_cap <= '0;
            r_width_cnt <= CNT_WIDTH'(1);
            r_wsat      <= 1'b0;
            r_state     <= ST_WIDTH_COUNT;
          end else if (w_ref_rise) begin
            r_phase_cnt <= CNT_WIDTH'(1);
            r_state     <= ST_PHASE_COUNT;
          end
        end
        ST_PHASE_COUNT: begin
          if (!ch_en) begin
            r_state <= ST_IDLE;
          end else if (w_trig_rise) begin
            r_phase_cap <= w_ref_rise ? '0 : r_phase_cnt;
            r_width_cnt <= CNT_WIDTH'(1);
            r_wsat      <= 1'b0;
            r_state     <= ST_WIDTH_COUNT;
          end else if (w_ref_rise) begin
            r_phase_cnt <= CNT_WIDTH'(1);
          end else if (timeout_limit != '0 && r_phase_cnt == timeout_limit) begin
            r_phase <= timeout_limit;
            r_width <= '0;
            r_err   <= err_pack(1'b0, 1'b1, 1'b0);
            r_valid <= 1'b1;
            r_state <= ST_REPORT;
          end else if (r_phase_cnt != '1) begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        ST_WIDTH_COUNT: begin
          if (!ch_en) begin
            r_state <= ST_IDLE;
          end else if (w_trig_fall) begin
            r_phase <= r_phase_cap;
            r_width <= r_width_cnt;
            r_err   <= err_pack(r_wsat, 1'b0, r_width_cnt != bsync_ratio);
            r_valid <= 1'b1;
            r_state <= ST_REPORT;
          end else if (w_trig_q) begin
            if (r_width_cnt == '1) r_wsat <= 1'b1;
            else                   r_width_cnt <= r_width_cnt + 1'b1;
          end
        end
        ST_REPORT: begin
          if (r_valid && meas_ready) begin
            r_valid <= 1'b0;
            r_state <= ch_en ? ST_ARMED : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign meas_valid = r_valid;
  assign meas_phase = r_phase;
  assign meas_width = r_width;
  assign meas_err   = r_err;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_trigger_capture.sv
// Scoreboard bench for trigger_capture: expected results queued at stimulus time, checked at handshake.
module tb_trigger_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch_en = 1'b0;
  logic        bsync_ref = 1'b0;
  logic        trig_in = 1'b0;
  logic [15:0] bsync_ratio = 16'd8;
  logic [15:0] timeout_limit = 16'd0;
  logic        meas_valid;
  logic        meas_ready = 1'b1;
  logic [15:0] meas_phase;
  logic [15:0] meas_width;
  logic [2:0]  meas_err;
  logic [7:0]  drop_cnt;

  typedef struct {
    int unsigned phase;
    int unsigned width;
    int unsigned err;
    int unsigned edge_no;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;

  trigger_capture #(.CNT_WIDTH(16), .DROP_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_en         (ch_en),
    .bsync_ref     (bsync_ref),
    .trig_in       (trig_in),
    .bsync_ratio   (bsync_ratio),
    .timeout_limit (timeout_limit),
    .meas_valid    (meas_valid),
    .meas_ready    (meas_ready),
    .meas_phase    (meas_phase),
    .meas_width    (meas_width),
    .meas_err      (meas_err),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-16s obs=%0d exp=%0d ok", tag, obs, exp);
    end else begin
      $display("FAIL %-16s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: valid-rise timing, data at handshake, and valid dropping after transfer.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_hs) chk("valid_after_hs", meas_valid, 0);
      if (meas_valid && !prev_valid) begin
        if (sb.size() == 0) chk("spurious_valid", 1, 0);
        else                chk("valid_edge", cyc, sb[0].edge_no);
      end
      prev_hs = meas_valid && meas_ready;
      if (prev_hs) begin
        if (sb.size() == 0) begin
          chk("spurious_hs", 1, 0);
        end else begin
          exp_t it;
          it = sb.pop_front();
          chk("phase", meas_phase, it.phase);
          chk("width", meas_width, it.width);
          chk("err", meas_err, it.err);
        end
      end
      prev_valid = meas_valid;
    end
  end

  task automatic meas(input int ph, input int w);
    exp_t it;
    it.phase = ph;
    it.width = w;
    it.err   = (w != int'(bsync_ratio)) ? 1 : 0;
    for (int i = 0; i <= ph + w; i++) begin
      bsync_ref = (i < 2);
      trig_in   = (i >= ph) && (i < ph + w);
      if (i == ph + w) begin
        it.edge_no = cyc + 2;
        sb.push_back(it);
      end
      tick();
    end
    bsync_ref = 1'b0;
    trig_in   = 1'b0;
  endtask

  task automatic timeout_meas(input int tmo);
    exp_t it;
    it.phase   = tmo;
    it.width   = 0;
    it.err     = 2;
    it.edge_no = cyc + tmo + 2;
    sb.push_back(it);
    for (int i = 0; i < tmo + 4; i++) begin
      bsync_ref = (i < 2);
      tick();
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
    chk("drained", sb.size(), 0);
    tick();
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!meas_valid && k < 100) begin
      tick();
      k++;
    end
    if (!meas_valid) chk("valid_wait", 0, 1);
  endtask

  initial begin
    tick();
    tick();
    #1;
    chk("rst_valid", meas_valid, 0);
    chk("rst_phase", meas_phase, 0);
    chk("rst_width", meas_width, 0);
    chk("rst_err", meas_err, 0);
    chk("rst_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    ch_en = 1'b1;
    tick();
    tick();

    bsync_ratio = 16'd8;
    meas(5, 8);
    wait_drain();
    bsync_ratio = 16'd7;
    meas(5, 8);
    wait_drain();
    bsync_ratio = 16'd8;
    meas(0, 8);
    wait_drain();

    timeout_limit = 16'd10;
    timeout_meas(10);
    wait_drain();
    timeout_limit = 16'd0;

    // Result held back by ready while three more pulses arrive.
    meas_ready = 1'b0;
    meas(3, 8);
    wait_valid();
    for (int k = 0; k < 20; k++) begin
      trig_in = (k < 12) && ((k % 4) < 2);
      tick();
    end
    if (sb.size() != 0) begin
      chk("hold_phase", meas_phase, sb[0].phase);
      chk("hold_width", meas_width, sb[0].width);
      chk("hold_err", meas_err, sb[0].err);
    end else begin
      chk("hold_entry", 0, 1);
    end
    chk("hold_valid", meas_valid, 1);
    chk("drop_report", drop_cnt, 3);
    meas_ready = 1'b1;
    wait_drain();
    trig_in = 1'b1;
    tick();
    tick();
    trig_in = 1'b0;
    tick();
    tick();
    chk("drop_armed", drop_cnt, 4);

    // Channel disabled mid-pulse: no result expected.
    for (int i = 0; i < 8; i++) begin
      bsync_ref = (i < 2);
      trig_in   = (i >= 2);
      if (i == 5) ch_en = 1'b0;
      tick();
    end
    bsync_ref = 1'b0;
    trig_in   = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("abort_valid", meas_valid, 0);
    chk("abort_drop", drop_cnt, 4);
    ch_en = 1'b1;
    tick();
    tick();

    // Reset asserted while counting phase.
    bsync_ref = 1'b1;
    tick();
    tick();
    bsync_ref = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", meas_valid, 0);
    chk("mid_rst_phase", meas_phase, 0);
    chk("mid_rst_width", meas_width, 0);
    chk("mid_rst_err", meas_err, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_valid", meas_valid, 0);

    meas(4, 8);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
